// File: rtl/edge_period_rx_pkg.sv
// ---------------------------------------------------------------------------
// edge_period_rx_pkg
// Shared definitions for the edge/period receiver slice:
//   state_e              - measurement FSM encoding (IDLE / ARMED), 1 bit
//   DefaultWidth         - default counter / output width
//   DefaultTimeoutCycles - default loss-of-signal limit in clock cycles
// ---------------------------------------------------------------------------
package edge_period_rx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  localparam int unsigned DefaultWidth         = 32;
  localparam int unsigned DefaultTimeoutCycles = 2**24;

endpackage

// File: rtl/edge_period_rx_sync_bit.sv
// ---------------------------------------------------------------------------
// sync_bit
// Two-flop synchroniser for a single asynchronous input bit.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both flops to 0
//   d_i   - asynchronous input bit
//   q_o   - synchronised output (two clk edges of latency)
// ---------------------------------------------------------------------------
module sync_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // The first flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/edge_period_rx.sv
// ---------------------------------------------------------------------------
// edge_period_rx
// Measures the period and high time of an asynchronous square wave, in clk
// cycles, between consecutive rising edges, and offers each measurement
// through a valid/ready handshake.
// Parameters:
//   width          - width of the period/high counters and outputs
//   timeout_cycles - cycles without a rising edge before loss of signal
//                    (2 <= timeout_cycles <= 2**width-1, so counters never wrap)
// Ports:
//   clk     - clock, all state updates on the rising edge
//   rst_n   - asynchronous active-low reset
//   in      - asynchronous square wave input
//   period  - cycles between the last two detected rising edges
//   high    - cycles the synchronised input was high within that period
//   valid   - period/high hold an unconsumed measurement
//   ready   - consumer takes the measurement when valid && ready
//   timeout - one-cycle pulse on loss of signal
//   overrun - one-cycle pulse when an unconsumed measurement is overwritten
// All outputs are registered: no combinational path from in or ready.
// ---------------------------------------------------------------------------
module edge_period_rx
  import edge_period_rx_pkg::*;
#(
  parameter int unsigned width          = DefaultWidth,
  parameter int unsigned timeout_cycles = DefaultTimeoutCycles
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  output logic [width-1:0] period,
  output logic [width-1:0] high,
  output logic             valid,
  input  logic             ready,
  output logic             timeout,
  output logic             overrun
);

  localparam logic [width-1:0] TimeoutLimit = width'(timeout_cycles);
  localparam logic [width-1:0] One          = width'(1);

  state_e           state_q, state_d;
  logic             syncLevel;
  logic             prevLevel_q;
  logic             rise;
  logic             atLimit;
  logic             armEvt, measEvt, toEvt;
  logic [width-1:0] cnt_q, cnt_d;
  logic [width-1:0] hcnt_q, hcnt_d;
  logic [width-1:0] period_q, period_d;
  logic [width-1:0] high_q, high_d;
  logic [width-1:0] levelInc;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;

  sync_bit u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (in),
    .q_o   (syncLevel)
  );

  // The edge register resets to 0, so an input already high at reset release
  // is seen as a rise; in IDLE that only arms the measurement.
  assign rise     = syncLevel && !prevLevel_q;
  assign atLimit  = (cnt_q == TimeoutLimit);
  assign levelInc = {{(width-1){1'b0}}, syncLevel};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a rise always wins over the timeout limit in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise) state_d = ARMED;
      ARMED:   if (!rise && atLimit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM event decode consumed by the datapath.
  always_comb begin
    armEvt  = 1'b0;
    measEvt = 1'b0;
    toEvt   = 1'b0;
    case (state_q)
      IDLE:  armEvt = rise;
      ARMED: begin
        measEvt = rise;
        toEvt   = !rise && atLimit;
      end
      default: ;
    endcase
  end

  // Counters start at 1 on an edge so that edges P cycles apart read P, and
  // the edge cycle itself (input high) is counted as the first high cycle.
  always_comb begin
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = valid_q;
    timeout_d = toEvt;
    overrun_d = 1'b0;
    if (armEvt || measEvt) begin
      cnt_d  = One;
      hcnt_d = One;
    end else if (toEvt) begin
      cnt_d  = '0;
      hcnt_d = '0;
    end else if (state_q == ARMED) begin
      cnt_d  = cnt_q + One;
      hcnt_d = hcnt_q + levelInc;
    end
    if (measEvt) begin
      period_d  = cnt_q;
      high_d    = hcnt_q;
      valid_d   = 1'b1;
      overrun_d = valid_q && !ready;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prevLevel_q <= 1'b0;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      period_q    <= '0;
      high_q      <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      prevLevel_q <= syncLevel;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      period_q    <= period_d;
      high_q      <= high_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
    end
  end

  assign period  = period_q;
  assign high    = high_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_edge_period_rx.sv
// ---------------------------------------------------------------------------
// tb_edge_period_rx
// Two instances share one stimulus: dutA (width 32, timeout 20) for the
// directed timeout/coincidence scenarios, dutB (width 16, timeout 1000) for
// randomized edge spacing. 'sel' picks which instance is compared.
// The reference model works on the input waveform itself: the index of each
// rising edge of 'in', the gap between edges, and the number of high samples
// in that gap. A rising edge driven before clock edge k is acted on at k+2.
// ---------------------------------------------------------------------------
module tb_edge_period_rx;

  localparam int TA = 20;
  localparam int TB = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inSig;
  logic        readySig;
  logic [31:0] periodA, highA;
  logic        validA, timeoutA, overrunA;
  logic [15:0] periodB, highB;
  logic        validB, timeoutB, overrunB;

  int     checks = 0;
  int     errors = 0;
  bit     sel;
  int     modelT;
  int     cyc;
  bit     inHist [0:65535];
  bit     mArmed;
  int     mLastEdge;
  longint mPeriod, mHigh;
  bit     mValid, mTimeout, mOverrun;
  int     dropped, overrunSeen, timeoutSeen, toCyc;

  always #5 clk = ~clk;

  edge_period_rx #(.width(32), .timeout_cycles(TA)) dutA (
    .clk(clk), .rst_n(rst_n), .in(inSig), .period(periodA), .high(highA),
    .valid(validA), .ready(readySig), .timeout(timeoutA), .overrun(overrunA)
  );

  edge_period_rx #(.width(16), .timeout_cycles(TB)) dutB (
    .clk(clk), .rst_n(rst_n), .in(inSig), .period(periodB), .high(highB),
    .valid(validB), .ready(readySig), .timeout(timeoutB), .overrun(overrunB)
  );

  // Single comparison point: counts the check and reports any failure.
  task automatic check1(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compares every output of the selected instance against the model.
  task automatic checkOutput(input string tag);
    logic [63:0] p, h;
    logic v, t, o;
    if (sel) begin
      p = {48'b0, periodB}; h = {48'b0, highB};
      v = validB; t = timeoutB; o = overrunB;
    end else begin
      p = {32'b0, periodA}; h = {32'b0, highA};
      v = validA; t = timeoutA; o = overrunA;
    end
    check1({tag, "/valid"},   {63'b0, v}, {63'b0, mValid});
    check1({tag, "/timeout"}, {63'b0, t}, {63'b0, mTimeout});
    check1({tag, "/overrun"}, {63'b0, o}, {63'b0, mOverrun});
    check1({tag, "/period"},  p, 64'(mPeriod));
    check1({tag, "/high"},    h, 64'(mHigh));
    if (o === 1'b1) overrunSeen++;
    if (t === 1'b1) begin
      timeoutSeen++;
      toCyc = cyc;
    end
  endtask

  task automatic modelReset();
    cyc       = 0;
    inHist[0] = 1'b0;
    mArmed    = 1'b0;
    mLastEdge = 0;
    mPeriod   = 0;
    mHigh     = 0;
    mValid    = 1'b0;
    mTimeout  = 1'b0;
    mOverrun  = 1'b0;
  endtask

  // Drives one cycle of input, predicts the effect of the coming clock edge,
  // then checks the outputs half a cycle after that edge.
  task automatic applyStimulus(input bit inV, input bit rdyV, input string tag);
    int  p, e, gap;
    bit  rise;
    longint hs;
    inSig    = inV;
    readySig = rdyV;
    p = cyc + 1;
    inHist[p] = inV;
    e = p - 2;
    rise = (e >= 1) && inHist[e] && !inHist[e-1];
    gap = e - mLastEdge;
    mTimeout = 1'b0;
    mOverrun = 1'b0;
    if (rise && mArmed) begin
      hs = 0;
      for (int i = mLastEdge; i < e; i++) hs += longint'(inHist[i]);
      mOverrun = mValid && !rdyV;
      if (mOverrun) dropped++;
      mPeriod = gap;
      mHigh   = hs;
      mValid  = 1'b1;
    end else if (mValid && rdyV) begin
      mValid = 1'b0;
    end
    if (rise) begin
      mArmed    = 1'b1;
      mLastEdge = e;
    end else if (mArmed && gap == modelT) begin
      mArmed   = 1'b0;
      mTimeout = 1'b1;
    end
    @(negedge clk);
    cyc = p;
    checkOutput(tag);
  endtask

  task automatic doReset();
    rst_n    = 1'b0;
    inSig    = 1'b0;
    readySig = 1'b0;
    repeat (3) @(negedge clk);
    modelReset();
    checkOutput("reset");
    rst_n = 1'b1;
  endtask

  // rdyMode: 0 = ready low, 1 = ready high, 2 = random ready per cycle.
  task automatic squareWave(input int n, input int per, input int hi, input int rdyMode,
                            input string tag);
    bit r;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < per; c++) begin
        r = (rdyMode == 2) ? bit'($urandom_range(0, 1)) : (rdyMode == 1);
        applyStimulus(c < hi, r, tag);
      end
    end
  endtask

  initial begin
    int eA, gap, hi;
    bit holdLow;
    sel    = 1'b0;
    modelT = TA;
    dropped = 0; overrunSeen = 0; timeoutSeen = 0; toCyc = 0;
    @(negedge clk);
    doReset();

    // Input held low from reset: nothing happens.
    repeat (30) applyStimulus(1'b0, 1'b1, "idleLow");
    check1("idleNoTimeout", 64'(timeoutSeen), 64'd0);

    // Period 10, high 5, consumer always ready.
    squareWave(5, 10, 5, 1, "sq10");
    check1("sq10Period", {32'b0, periodA}, 64'd10);
    check1("sq10High",   {32'b0, highA},   64'd5);

    // Consumer stalled: every measurement after the first overwrites.
    overrunSeen = 0;
    squareWave(4, 8, 4, 0, "ovr8");
    check1("ovr8Count",  64'(overrunSeen), 64'd3);
    check1("ovr8Period", {32'b0, periodA}, 64'd8);
    check1("ovr8Valid",  {63'b0, validA},  64'd1);
    repeat (3) applyStimulus(1'b0, 1'b1, "drain");

    // Loss of signal: let it time out, then one arming edge and silence.
    repeat (25) applyStimulus(1'b0, 1'b1, "toFlush");
    timeoutSeen = 0;
    eA = cyc + 1;
    repeat (3)  applyStimulus(1'b1, 1'b1, "toEdge");
    repeat (40) applyStimulus(1'b0, 1'b1, "toQuiet");
    check1("toOnce",  64'(timeoutSeen), 64'd1);
    check1("toCycle", 64'(toCyc), 64'(eA + 2 + TA));

    // Next edge only re-arms; the following one measures.
    squareWave(2, 12, 6, 1, "rearm");
    check1("rearmPeriod", {32'b0, periodA}, 64'd12);
    check1("rearmHigh",   {32'b0, highA},   64'd6);

    // Edge spacing equal to the timeout limit: the edge wins.
    timeoutSeen = 0;
    squareWave(3, 20, 7, 1, "coin");
    check1("coinNoTimeout", 64'(timeoutSeen), 64'd0);
    check1("coinPeriod", {32'b0, periodA}, 64'd20);
    check1("coinHigh",   {32'b0, highA},   64'd7);

    // Asynchronous reset with a pending measurement.
    squareWave(2, 10, 5, 0, "preRst");
    repeat (3) applyStimulus(1'b0, 1'b0, "preRst");
    check1("preRstValid", {63'b0, validA}, 64'd1);
    #2 rst_n = 1'b0;
    #1 modelReset();
    checkOutput("asyncRst");
    @(negedge clk);
    rst_n = 1'b1;
    squareWave(3, 10, 4, 1, "postRst");

    // Input already high at reset release counts as an arming edge.
    doReset();
    inSig = 1'b1;
    repeat (4) applyStimulus(1'b1, 1'b0, "relHigh");
    repeat (6) applyStimulus(1'b0, 1'b0, "relHigh");
    repeat (3) applyStimulus(1'b1, 1'b0, "relHigh");
    check1("relHighPeriod", {32'b0, periodA}, 64'd10);
    check1("relHighHigh",   {32'b0, highA},   64'd4);

    // Randomized spacing against the long-timeout instance.
    sel    = 1'b1;
    modelT = TB;
    doReset();
    overrunSeen = 0;
    dropped     = 0;
    for (int k = 0; k < 30; k++) begin
      gap = int'($urandom_range(2, 1000));
      hi  = int'($urandom_range(1, gap - 1));
      holdLow = ($urandom_range(0, 2) == 0);
      for (int c = 0; c < gap; c++)
        applyStimulus(c < hi, holdLow ? 1'b0 : bit'($urandom_range(0, 1)), "rnd");
    end
    check1("rndOverruns", 64'(overrunSeen), 64'(dropped));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
